fifo_bank: RTL

Four-queue buffer bank that sits directly downstream of the round-robin scheduler. It consumes the scheduler's `pop_id`/`valid` pair, pops the selected queue, and presents the popped word with its queue id. It also returns the per-queue `empty` vector that the scheduler samples. Each queue has its own independent push port from the upstream producers.

---
 rtl/fifo_bank_if.sv | 28 ++
 rtl/fifo_bank.sv | 73 +++++++
 2 files changed

// File: rtl/fifo_bank_if.sv
// fifo_bank_if: push/pop bus between producers, the round-robin scheduler and the fifo_bank.
// The master side drives pushes and pop requests; the slave side is the bank itself.
interface fifo_bank_if #(
    parameter int DATA_WIDTH = 8
);
    logic [3:0]            push;
    logic [DATA_WIDTH-1:0] data_in0;
    logic [DATA_WIDTH-1:0] data_in1;
    logic [DATA_WIDTH-1:0] data_in2;
    logic [DATA_WIDTH-1:0] data_in3;
    logic [1:0]            pop_id;
    logic                  valid;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_out_valid;
    logic [1:0]            out_id;
    logic [3:0]            empty;
    logic [3:0]            full;
    logic [3:0]            overflow;
    logic [3:0]            underflow;
    modport master (
        output push, data_in0, data_in1, data_in2, data_in3, pop_id, valid,
        input  data_out, data_out_valid, out_id, empty, full, overflow, underflow
    );
    modport slave (
        input  push, data_in0, data_in1, data_in2, data_in3, pop_id, valid,
        output data_out, data_out_valid, out_id, empty, full, overflow, underflow
    );
endinterface

// File: rtl/fifo_bank.sv
// fifo_bank: four independent FIFOs with per-queue push, a scheduler-selected registered pop,
// registered-count empty/full flags and sticky overflow/underflow flags.
module fifo_bank #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int PTR_WIDTH  = 3
) (
    input logic        clk,
    input logic        reset,
    fifo_bank_if.slave bus
);
    logic [DATA_WIDTH-1:0] mem [4][DEPTH];
    logic [DATA_WIDTH-1:0] din [4];
    logic [PTR_WIDTH-1:0]  wp [4];
    logic [PTR_WIDTH-1:0]  rp [4];
    logic [PTR_WIDTH:0]    cnt [4];
    logic [3:0]            emp;
    logic [3:0]            ful;
    logic [3:0]            pop_sel;
    logic [3:0]            push_ok;
    logic                  pop_ok;
    assign din[0] = bus.data_in0;
    assign din[1] = bus.data_in1;
    assign din[2] = bus.data_in2;
    assign din[3] = bus.data_in3;
    assign bus.empty = emp;
    assign bus.full  = ful;
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            emp[i] = cnt[i] == '0;
            ful[i] = cnt[i] == (PTR_WIDTH + 1)'(DEPTH);
        end
    end
    // A push into a full queue is still accepted when that queue is popped the same cycle.
    always_comb begin
        pop_ok = bus.valid && !emp[bus.pop_id];
        for (int i = 0; i < 4; i++) begin
            pop_sel[i] = pop_ok && bus.pop_id == 2'(i);
            push_ok[i] = bus.push[i] && (!ful[i] || pop_sel[i]);
        end
    end
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (push_ok[i]) mem[i][wp[i]] <= din[i];
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                wp[i]  <= '0;
                rp[i]  <= '0;
                cnt[i] <= '0;
            end
            bus.data_out       <= '0;
            bus.data_out_valid <= 1'b0;
            bus.out_id         <= '0;
            bus.overflow       <= '0;
            bus.underflow      <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (push_ok[i]) wp[i] <= wp[i] + PTR_WIDTH'(1);
                if (pop_sel[i]) rp[i] <= rp[i] + PTR_WIDTH'(1);
                cnt[i] <= cnt[i] + (PTR_WIDTH + 1)'(push_ok[i]) - (PTR_WIDTH + 1)'(pop_sel[i]);
                if (bus.push[i] && !push_ok[i]) bus.overflow[i] <= 1'b1;
            end
            if (bus.valid && !pop_ok) bus.underflow[bus.pop_id] <= 1'b1;
            bus.data_out_valid <= pop_ok;
            if (pop_ok) begin
                bus.data_out <= mem[bus.pop_id][rp[bus.pop_id]];
                bus.out_id   <= bus.pop_id;
            end
        end
    end
endmodule
